// File: rtl/decoder_select_sequencer_if.sv
// Control/status bundle between the scan controller and decoder_select_sequencer.
// master = controlling logic, slave = the sequencer itself.
interface decoder_select_sequencer_if #(
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned DWELL_WIDTH = 8
);
    logic                       start;
    logic                       stop;
    logic                       loop;
    logic [DWELL_WIDTH-1:0]     dwell;
    logic [(2**SEL_WIDTH)-1:0]  mask;
    logic [SEL_WIDTH-1:0]       select;
    logic                       enable;
    logic                       strobe;
    logic                       busy;
    logic                       done;

    modport master (
        output start, stop, loop, dwell, mask,
        input  select, enable, strobe, busy, done
    );

    modport slave (
        input  start, stop, loop, dwell, mask,
        output select, enable, strobe, busy, done
    );
endinterface

// File: rtl/decoder_select_sequencer.sv
// Steps a 3-to-8 decoder through the lines set in a mask, holding each for dwell+1 cycles.
// Define SEQ_BREAK_BEFORE_MAKE_EN to insert one enable-low GAP cycle between consecutive lines.
module decoder_select_sequencer #(
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned DWELL_WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst,
    decoder_select_sequencer_if.slave bus
);
    localparam int unsigned LINES = 2**SEL_WIDTH;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [LINES-1:0]       mask_q, mask_d;
    logic                   loop_q, loop_d;
    logic                   en_q, en_d;
    logic                   stb_q, stb_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // {found, index} of the lowest set bit of m at or above position from
    function automatic logic [SEL_WIDTH:0] lowest_from(input logic [LINES-1:0] m,
                                                       input int unsigned from);
        logic [SEL_WIDTH:0] r;
        r = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (!r[SEL_WIDTH] && (i >= from) && m[i]) begin
                r = {1'b1, i[SEL_WIDTH-1:0]};
            end
        end
        return r;
    endfunction

    logic [SEL_WIDTH:0]   start_hit, next_hit, wrap_hit;
    logic                 have_target;
    logic [SEL_WIDTH-1:0] target;

    assign start_hit   = lowest_from(bus.mask, 0);
    assign next_hit    = lowest_from(mask_q, 32'(sel_q) + 32'd1);
    assign wrap_hit    = lowest_from(mask_q, 0);
    assign have_target = next_hit[SEL_WIDTH] | (loop_q & wrap_hit[SEL_WIDTH]);
    assign target      = next_hit[SEL_WIDTH] ? next_hit[SEL_WIDTH-1:0] : wrap_hit[SEL_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        loop_d  = loop_q;
        en_d    = 1'b0;
        stb_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (state_q != IDLE && bus.stop) begin
            state_d = IDLE;
            sel_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        dwell_d = bus.dwell;
                        mask_d  = bus.mask;
                        loop_d  = bus.loop;
                        if (!start_hit[SEL_WIDTH]) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ACTIVE;
                            sel_d   = start_hit[SEL_WIDTH-1:0];
                            cnt_d   = bus.dwell;
                            en_d    = 1'b1;
                            stb_d   = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - DWELL_WIDTH'(1);
                        en_d   = 1'b1;
                        busy_d = 1'b1;
                    end else if (have_target) begin
                        sel_d  = target;
                        busy_d = 1'b1;
`ifdef SEQ_BREAK_BEFORE_MAKE_EN
                        state_d = GAP;
`else
                        // make-before-break: new line starts in the same cycle enable stays high
                        cnt_d   = dwell_q;
                        en_d    = 1'b1;
                        stb_d   = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                        sel_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                GAP: begin
                    state_d = ACTIVE;
                    cnt_d   = dwell_q;
                    en_d    = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            loop_q  <= 1'b0;
            en_q    <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            loop_q  <= loop_d;
            en_q    <= en_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.select = sel_q;
    assign bus.enable = en_q;
    assign bus.strobe = stb_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Bench for decoder_select_sequencer: per-cycle comparison against a schedule-queue model,
// directed scans with literal expectations, then randomized start/stop/reset traffic.
module tb_decoder_select_sequencer;
    localparam int SW = 3;
    localparam int DW = 8;
`ifdef SEQ_BREAK_BEFORE_MAKE_EN
    localparam bit GAPS = 1'b1;
`else
    localparam bit GAPS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_select_sequencer_if #(.SEL_WIDTH(SW), .DWELL_WIDTH(DW)) bus();

    decoder_select_sequencer #(.SEL_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // One expected output cycle; sel_chk=0 means select is don't-care (DONE cycle)
    typedef struct packed {
        logic          sel_chk;
        logic [SW-1:0] sel;
        logic          en;
        logic          stb;
        logic          busy;
        logic          done;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    bit         run;
    bit         m_loop;
    logic [7:0] m_mask;
    int         m_dwell;

    int cyc = 0;
    int en_cnt, done_cnt, first_en, done_at;
    int stb_sel[$];
    int stb_off[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(input bit chk, input int s, input bit en, input bit stb,
                                input bit busy, input bit done);
        rec_t r;
        r.sel_chk = chk;
        r.sel     = s[SW-1:0];
        r.en      = en;
        r.stb     = stb;
        r.busy    = busy;
        r.done    = done;
        return r;
    endfunction

    // Append one full pass over the latched mask to the expected schedule
    task automatic add_pass(input bit lead_gap);
        bit first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_mask[i]) begin
                if (GAPS && (!first || lead_gap)) q.push_back(mk(1, i, 0, 0, 1, 0));
                for (int c = 0; c <= m_dwell; c++) q.push_back(mk(1, i, 1, c == 0, 1, 0));
                first = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        rec_t idle_r = mk(1, 0, 0, 0, 0, 0);
        if (rst) begin
            q.delete(); run = 0; cur = idle_r;
        end else if (run) begin
            if (bus.stop) begin
                q.delete(); run = 0; cur = idle_r;
            end else begin
                if (q.size() == 0 && m_loop) add_pass(1);
                if (q.size() == 0) begin
                    run = 0; cur = idle_r;
                end else begin
                    cur = q.pop_front();
                end
            end
        end else if (bus.start && !bus.stop) begin
            m_mask = bus.mask; m_dwell = int'(bus.dwell); m_loop = bus.loop;
            run = 1;
            if (m_mask == 8'h00) begin
                q.push_back(mk(0, 0, 0, 0, 0, 1));
            end else begin
                add_pass(0);
                if (!m_loop) q.push_back(mk(0, 0, 0, 0, 0, 1));
            end
            cur = q.pop_front();
        end else begin
            cur = idle_r;
        end
    endtask

    task automatic clear_stats();
        en_cnt = 0; done_cnt = 0; first_en = -1; done_at = -1;
        stb_sel.delete(); stb_off.delete();
    endtask

    task automatic cycle();
        int a, e;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        a = {(cur.sel_chk ? bus.select : 3'd0), bus.enable, bus.strobe, bus.busy, bus.done};
        e = {(cur.sel_chk ? cur.sel : 3'd0), cur.en, cur.stb, cur.busy, cur.done};
        check("outputs{sel,en,stb,busy,done}", a, e);
        if (bus.enable === 1'b1) begin
            if (first_en < 0) first_en = cyc;
            en_cnt++;
        end
        if (bus.strobe === 1'b1) begin
            stb_sel.push_back(int'(bus.select));
            stb_off.push_back(cyc - first_en);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, input logic l);
        bus.mask = m; bus.dwell = d; bus.loop = l; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget && run; i++) cycle();
        check("scan_end_within_budget", int'(run), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        bus.dwell = '0; bus.mask = '0;
        run = 0; m_loop = 0; m_mask = '0; m_dwell = 0;
        cur = mk(1, 0, 0, 0, 0, 0);
        clear_stats();
        repeat (3) cycle();
        rst = 1'b0;
        check("reset_outputs", int'({bus.select, bus.enable, bus.strobe, bus.busy, bus.done}), 0);

        // Full mask, dwell 2, single pass
        clear_stats();
        pulse_start(8'hFF, 8'd2, 1'b0);
        check("first_cycle_enable_busy_strobe", int'({bus.enable, bus.busy, bus.strobe}), 7);
        run_until_idle(100);
        check("ff_enable_cycles", en_cnt, 24);
        check("ff_strobes", stb_sel.size(), 8);
        check("ff_done_pulses", done_cnt, 1);
        check("ff_done_offset", done_at - first_en, GAPS ? 31 : 24);
        for (int i = 0; i < 8; i++)
            check("ff_strobe_select", (i < stb_sel.size()) ? stb_sel[i] : -1, i);

        // Two lines, dwell 1
        clear_stats();
        pulse_start(8'h03, 8'd1, 1'b0);
        run_until_idle(20);
        check("m03_enable_cycles", en_cnt, 4);
        check("m03_strobe0_sel", (stb_sel.size() > 0) ? stb_sel[0] : -1, 0);
        check("m03_strobe1_sel", (stb_sel.size() > 1) ? stb_sel[1] : -1, 1);
        check("m03_strobe1_offset", (stb_off.size() > 1) ? stb_off[1] : -1, GAPS ? 3 : 2);
        check("m03_done_offset", done_at - first_en, GAPS ? 5 : 4);

        // Looping scan, dwell 0; a mid-scan start must be ignored
        clear_stats();
        pulse_start(8'b1010_0100, 8'd0, 1'b1);
        repeat (4) cycle();
        pulse_start(8'h01, 8'd5, 1'b0);
        repeat (10) cycle();
        begin
            int exp_seq[6] = '{2, 5, 7, 2, 5, 7};
            for (int i = 0; i < 6; i++)
                check("loop_strobe_select", (i < stb_sel.size()) ? stb_sel[i] : -1, exp_seq[i]);
        end
        check("loop_no_done", done_cnt, 0);
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        check("stop_enable_busy", int'({bus.enable, bus.busy}), 0);
        repeat (4) cycle();
        check("stop_no_done", done_cnt, 0);

        // Empty mask: done right after start, no enable
        clear_stats();
        pulse_start(8'h00, 8'd3, 1'b0);
        check("empty_mask_done", int'({bus.done, bus.enable, bus.busy}), 4);
        cycle();
        check("empty_mask_done_cleared", int'(bus.done), 0);
        check("empty_mask_no_enable", en_cnt, 0);

        // Start and stop together in IDLE
        bus.mask = 8'hFF; bus.dwell = 8'd1; bus.start = 1'b1; bus.stop = 1'b1;
        cycle();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_together", int'({bus.enable, bus.busy}), 0);

        // Maximum dwell on a single line
        clear_stats();
        pulse_start(8'h01, 8'hFF, 1'b0);
        run_until_idle(300);
        check("maxdwell_enable_cycles", en_cnt, 256);
        check("maxdwell_done_offset", done_at - first_en, 256);

        // Reset mid-scan, then a normal scan
        pulse_start(8'hFF, 8'd3, 1'b1);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        check("midscan_reset_outputs", int'({bus.select, bus.enable, bus.strobe, bus.busy, bus.done}), 0);
        cycle();
        rst = 1'b0;
        clear_stats();
        pulse_start(8'h81, 8'd0, 1'b0);
        run_until_idle(20);
        check("post_reset_strobes", stb_sel.size(), 2);
        check("post_reset_last_sel", (stb_sel.size() > 1) ? stb_sel[1] : -1, 7);
        check("post_reset_done", done_cnt, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            bus.start = ($urandom_range(0, 9) == 0);
            bus.stop  = ($urandom_range(0, 59) == 0);
            bus.loop  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       bus.mask = 8'h00;
                1:       bus.mask = 8'h01 << $urandom_range(0, 7);
                default: bus.mask = 8'($urandom);
            endcase
            bus.dwell = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                                    : 8'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
